// File: rtl/mem_port_arbiter.sv
// Two-port sequencer/arbiter for the single Pmmu memory port (IDLE -> ACCESS -> ACK).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (port 0).
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  p0_req_i,
  input  logic                  p0_wr_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wd_i,
  input  logic [2:0]            p0_funct3_i,
  output logic [DATA_WIDTH-1:0] p0_rd_o,
  output logic                  p0_ack_o,
  output logic                  p0_err_o,
  output logic                  p0_busy_o,
  input  logic                  p1_req_i,
  input  logic                  p1_wr_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wd_i,
  input  logic [2:0]            p1_funct3_i,
  output logic [DATA_WIDTH-1:0] p1_rd_o,
  output logic                  p1_ack_o,
  output logic                  p1_err_o,
  output logic                  p1_busy_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  output logic [2:0]            mem_funct3_o,
  output logic                  mem_wr_o,
  output logic                  mem_rd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i,
  input  logic                  mem_rdy_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

  state_t                       state, state_nxt;
  logic [1:0]                   req, ack;
  logic                         sel, owner, wr_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [DATA_WIDTH-1:0]        wd_q;
  logic [2:0]                   f3_q;
  logic [7:0]                   cnt;
  logic [1:0][DATA_WIDTH-1:0]   rd_q;
  logic [1:0]                   err_q;
  logic                         done_ok, done_tmo;

  assign req      = {p1_req_i, p0_req_i};
  assign done_ok  = (state == ACCESS) && mem_rdy_i;
  // cnt counts completed wait cycles, so the TIMEOUT_CYCLES-th ACCESS cycle aborts
  assign done_tmo = (state == ACCESS) && !mem_rdy_i && (cnt == TMO_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  assign sel = (&req) ? ~last_owner : ~req[0];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)           last_owner <= 1'b1;
    else if (state == ACK)  last_owner <= owner;
  end
`else
  assign sel = ~req[0];
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  if (done_ok || done_tmo) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_o = 1'b0;
    mem_wr_o = 1'b0;
    ack      = 2'b00;
    case (state)
      ACCESS: begin
        mem_wr_o = wr_q;
        mem_rd_o = ~wr_q;
      end
      ACK:     ack = owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      owner  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      f3_q   <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      err_q  <= '0;
    end else begin
      if (state == IDLE && |req) begin
        owner  <= sel;
        wr_q   <= sel ? p1_wr_i     : p0_wr_i;
        addr_q <= sel ? p1_addr_i   : p0_addr_i;
        wd_q   <= sel ? p1_wd_i     : p0_wd_i;
        f3_q   <= sel ? p1_funct3_i : p0_funct3_i;
        cnt    <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 8'd1;
      if (done_ok) begin
        if (!wr_q) rd_q[owner] <= mem_rd_i;
        err_q[owner] <= 1'b0;
      end
      if (done_tmo) err_q[owner] <= 1'b1;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_wd_o     = wd_q;
  assign mem_funct3_o = f3_q;

  assign p0_rd_o   = rd_q[0];
  assign p1_rd_o   = rd_q[1];
  assign p0_ack_o  = ack[0];
  assign p1_ack_o  = ack[1];
  assign p0_err_o  = err_q[0];
  assign p1_err_o  = err_q[1];
  // gated by reset so every output reads 0 while reset is held
  assign p0_busy_o = p0_req_i & ~ack[0] & reset_i;
  assign p1_busy_o = p1_req_i & ~ack[1] & reset_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// (winner choice, expected latency, read-data and error bookkeeping per port).
module tb_mem_port_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic [1:0]        req, wr;
  logic [1:0][31:0]  addr, wd;
  logic [1:0][2:0]   f3;
  logic [31:0]       mem_rd_i;
  logic              mem_rdy_i;

  logic [31:0] p0_rd, p1_rd, mem_addr, mem_wd;
  logic [2:0]  mem_f3;
  logic        p0_ack, p1_ack, p0_err, p1_err, p0_busy, p1_busy, mem_wr, mem_rd;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .p0_req_i(req[0]), .p0_wr_i(wr[0]), .p0_addr_i(addr[0]), .p0_wd_i(wd[0]),
    .p0_funct3_i(f3[0]), .p0_rd_o(p0_rd), .p0_ack_o(p0_ack), .p0_err_o(p0_err),
    .p0_busy_o(p0_busy),
    .p1_req_i(req[1]), .p1_wr_i(wr[1]), .p1_addr_i(addr[1]), .p1_wd_i(wd[1]),
    .p1_funct3_i(f3[1]), .p1_rd_o(p1_rd), .p1_ack_o(p1_ack), .p1_err_o(p1_err),
    .p1_busy_o(p1_busy),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_funct3_o(mem_f3),
    .mem_wr_o(mem_wr), .mem_rd_o(mem_rd), .mem_rd_i(mem_rd_i), .mem_rdy_i(mem_rdy_i)
  );

  // reference model state
  logic        m_wr[2];
  logic [31:0] m_addr[2], m_wd[2], m_rd[2];
  logic [2:0]  m_f3[2];
  int          last_own;
  int          n_chk = 0, n_fail = 0;
  int          grants[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int p);
    m_wr[p] = 1'($urandom); m_addr[p] = $urandom; m_wd[p] = $urandom; m_f3[p] = 3'($urandom);
    wr[p] = m_wr[p]; addr[p] = m_addr[p]; wd[p] = m_wd[p]; f3[p] = m_f3[p];
    req[p] = 1'b1;
  endtask

  // Called at a negedge in an IDLE cycle with requests driven; returns at the
  // negedge of the ack cycle. lat < 0 means the memory never answers.
  task automatic run_round(input int lat);
    int w, limit;
    logic [31:0] data;
    logic err_e;
    if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = (last_own == 1) ? 0 : 1;
`else
      w = 0;
`endif
    end else w = req[1] ? 1 : 0;
    limit = (lat < 0) ? TMO : lat + 1;
    data = $urandom;
    grants.push_back(w);
    @(posedge clk);
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      chk("strobe", {mem_rd, mem_wr}, m_wr[w] ? 2'b01 : 2'b10);
      chk("addr", mem_addr, m_addr[w]);
      chk("wd_f3", {mem_wd, mem_f3}, {m_wd[w], m_f3[w]});
      chk("ack_busy", {p1_ack, p0_ack, p1_busy, p0_busy}, {2'b00, req});
      if (i == 1) begin
        addr[w] = ~m_addr[w]; wd[w] = ~m_wd[w]; f3[w] = ~m_f3[w];
      end
      mem_rdy_i = (lat >= 0 && i == lat + 1);
      mem_rd_i  = data;
    end
    @(negedge clk);
    mem_rdy_i = 1'b0;
    mem_rd_i  = $urandom;
    err_e = (lat < 0);
    if (!err_e && !m_wr[w]) m_rd[w] = data;
    chk("ack", {p1_ack, p0_ack}, (w == 1) ? 2'b10 : 2'b01);
    chk("err", (w == 1) ? p1_err : p0_err, err_e);
    chk("rd0", p0_rd, m_rd[0]);
    chk("rd1", p1_rd, m_rd[1]);
    chk("ack_strobe", {mem_rd, mem_wr}, 2'b00);
    chk("busy_ack", (w == 1) ? {p1_busy, p0_busy} : {p0_busy, p1_busy}, {1'b0, req[1-w]});
    last_own = w;
    req[w] = 1'b0;
  endtask

  initial begin
    int lat;
    reset_i = 1'b0; req = 2'b11; wr = '0; addr = '1; wd = '1; f3 = '1;
    mem_rd_i = '0; mem_rdy_i = 1'b0;
    for (int p = 0; p < 2; p++) begin m_rd[p] = '0; m_wr[p] = 1'b0; end
    last_own = 1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {mem_rd, mem_wr, p0_ack, p1_ack, p0_err, p1_err, p0_busy, p1_busy}, 8'h0);
    chk("rst_bus", {mem_addr, mem_wd}, 64'h0);
    chk("rst_rd", {p0_rd, p1_rd}, 64'h0);
    chk("rst_f3", mem_f3, 3'h0);
    req = 2'b00;
    reset_i = 1'b1;

    // directed single read: p0, addr 0x40, funct3 010, ready in first ACCESS cycle
    @(negedge clk);
    m_wr[0] = 1'b0; m_addr[0] = 32'h40; m_wd[0] = 32'h0; m_f3[0] = 3'b010;
    wr[0] = 1'b0; addr[0] = 32'h40; wd[0] = 32'h0; f3[0] = 3'b010; req[0] = 1'b1;
    run_round(0);

    // directed write with 4 wait states on p1
    @(negedge clk);
    m_wr[1] = 1'b1; m_addr[1] = 32'h100; m_wd[1] = 32'hDEADBEEF; m_f3[1] = 3'b010;
    wr[1] = 1'b1; addr[1] = 32'h100; wd[1] = 32'hDEADBEEF; f3[1] = 3'b010; req[1] = 1'b1;
    run_round(4);

    // directed timeout on p0
    @(negedge clk);
    new_req(0);
    run_round(-1);

    // random traffic
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 1) == 1) new_req(p);
      if (req == 2'b00) new_req(int'($urandom_range(0, 1)));
      lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
      run_round(lat);
    end

    // continuous contention: both ports keep requesting
    while (grants.size() > 0) void'(grants.pop_front());
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (!req[p]) new_req(p);
      run_round(int'($urandom_range(0, 2)));
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr_alt", {grants[0] != grants[1], grants[1] != grants[2], grants[2] != grants[3]}, 3'b111);
`else
    chk("fixed_prio", {grants[0], grants[1], grants[2], grants[3]}, 128'h0);
`endif

    // reset during a wait state, then a pending p0 request is served normally
    @(negedge clk);
    req[1] = 1'b0;
    if (!req[0]) new_req(0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("mid_rst_strobe", {mem_rd, mem_wr, p0_ack, p1_ack}, 4'h0);
    chk("mid_rst_regs", {p0_rd, p1_rd, mem_addr, p0_err, p1_err}, 98'h0);
    m_rd[0] = '0; m_rd[1] = '0; last_own = 1;
    @(negedge clk);
    chk("mid_rst_noack", {p0_ack, p1_ack}, 2'b00);
    reset_i = 1'b1;
    run_round(1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
